// File: rtl/hc_mmio_rd_responder.sv
// HardCloud CSR read responder: snoops host MMIO writes into shadow registers and
// answers MMIO reads on the c2 channel with a fixed two-cycle latency.

package hc_ccip_pkg;
    typedef struct packed {
        logic [15:0] address;   // dword units
        logic [1:0]  length;    // 0: 4B, 1: 8B, 2: 64B
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;
endpackage

module hc_mmio_rd_responder
    import hc_ccip_pkg::*;
#(
    parameter logic [63:0] AFU_ID_L       = 64'h0,
    parameter logic [63:0] AFU_ID_H       = 64'h0,
    parameter int          HC_BUFFER_SIZE = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  t_if_ccip_c0_Rx rx_mmio_channel,
    output t_if_ccip_c2_Tx tx_mmio_channel,
    input  logic [63:0]    hc_status
);

    localparam logic [63:0] DFH      = 64'h1000_0100_0000_0000;
    // 64-bit word indices (byte offset >> 3); buffer slots must stay below W_CNT.
    localparam logic [8:0]  W_DFH    = 9'h000;
    localparam logic [8:0]  W_ID_L   = 9'h001;
    localparam logic [8:0]  W_ID_H   = 9'h002;
    localparam logic [8:0]  W_DSM    = 9'h022;
    localparam logic [8:0]  W_CTRL   = 9'h023;
    localparam logic [8:0]  W_BUF0   = 9'h024;
    localparam logic [8:0]  W_CNT    = 9'h040;
    localparam logic [8:0]  W_STATUS = 9'h041;

    t_ccip_c0_ReqMmioHdr hdr;
    logic                owned;
    logic                wr_en;
    logic                rd_en;
    logic [8:0]          word_idx;
    logic [63:0]         wdata;
    logic                unused_bits;

    assign hdr      = rx_mmio_channel.hdr;
    assign owned    = (hdr.address[15:10] == 6'd0);
    assign wr_en    = rx_mmio_channel.mmioWrValid && owned;
    assign rd_en    = rx_mmio_channel.mmioRdValid && owned;
    assign word_idx = hdr.address[9:1];
    assign wdata    = rx_mmio_channel.data[63:0];
    assign unused_bits = ^{rx_mmio_channel.data[511:64], rx_mmio_channel.rspValid, hdr.rsvd};

    function automatic logic [63:0] merge64(input logic [63:0] old, input logic [63:0] wd,
                                            input logic [1:0] len, input logic hi);
        if (len != 2'd0) return wd;
        if (hi)          return {wd[31:0], old[31:0]};
        return {old[63:32], wd[31:0]};
    endfunction

    // 32-bit shadows only ever take the low data lane; upper-half 4B writes are dropped.
    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [63:0] wd,
                                            input logic [1:0] len, input logic hi);
        if (len == 2'd0 && hi) return old;
        return wd[31:0];
    endfunction

    logic [63:0] dsm, dsm_nxt;
    logic [31:0] ctrl, ctrl_nxt;
    logic [63:0] buf_addr     [HC_BUFFER_SIZE];
    logic [63:0] buf_addr_nxt [HC_BUFFER_SIZE];
    logic [31:0] buf_size     [HC_BUFFER_SIZE];
    logic [31:0] buf_size_nxt [HC_BUFFER_SIZE];

    always_comb begin
        dsm_nxt      = dsm;
        ctrl_nxt     = ctrl;
        buf_addr_nxt = buf_addr;
        buf_size_nxt = buf_size;
        if (wr_en) begin
            if (word_idx == W_DSM)
                dsm_nxt = merge64(dsm, wdata, hdr.length, hdr.address[0]);
            if (word_idx == W_CTRL)
                ctrl_nxt = merge32(ctrl, wdata, hdr.length, hdr.address[0]);
            for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
                if (word_idx == W_BUF0 + 9'(2 * i))
                    buf_addr_nxt[i] = merge64(buf_addr[i], wdata, hdr.length, hdr.address[0]);
                if (word_idx == W_BUF0 + 9'(2 * i + 1))
                    buf_size_nxt[i] = merge32(buf_size[i], wdata, hdr.length, hdr.address[0]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsm  <= '0;
            ctrl <= '0;
            for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
                buf_addr[i] <= '0;
                buf_size[i] <= '0;
            end
        end else begin
            dsm      <= dsm_nxt;
            ctrl     <= ctrl_nxt;
            buf_addr <= buf_addr_nxt;
            buf_size <= buf_size_nxt;
        end
    end

    logic [31:0] rd_count;
    logic        s1_valid;
    logic [8:0]  s1_tid;
    logic [8:0]  s1_idx;
    logic        s1_hi;
    logic [1:0]  s1_len;
    logic [31:0] s1_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            s1_valid <= 1'b0;
            s1_tid   <= '0;
            s1_idx   <= '0;
            s1_hi    <= 1'b0;
            s1_len   <= '0;
            s1_cnt   <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                rd_count <= rd_count + 32'd1;
                s1_tid   <= hdr.tid;
                s1_idx   <= word_idx;
                s1_hi    <= hdr.address[0];
                s1_len   <= hdr.length;
                s1_cnt   <= rd_count;
            end
        end
    end

    // S2 selects from the *_nxt shadows so a write arriving one cycle after the read still lands.
    logic [63:0] rd_word;
    logic [63:0] rd_data;

    always_comb begin
        rd_word = '0;
        case (s1_idx)
            W_DFH:    rd_word = DFH;
            W_ID_L:   rd_word = AFU_ID_L;
            W_ID_H:   rd_word = AFU_ID_H;
            W_DSM:    rd_word = dsm_nxt;
            W_CTRL:   rd_word = {32'h0, ctrl_nxt};
            W_CNT:    rd_word = {32'h0, s1_cnt};
            W_STATUS: rd_word = hc_status;
            default:  rd_word = '0;
        endcase
        for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
            if (s1_idx == W_BUF0 + 9'(2 * i))     rd_word = buf_addr_nxt[i];
            if (s1_idx == W_BUF0 + 9'(2 * i + 1)) rd_word = {32'h0, buf_size_nxt[i]};
        end
        if (s1_len != 2'd0) rd_data = rd_word;
        else if (s1_hi)     rd_data = {32'h0, rd_word[63:32]};
        else                rd_data = {32'h0, rd_word[31:0]};
    end

    logic        tx_valid;
    logic [8:0]  tx_tid;
    logic [63:0] tx_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_tid   <= '0;
            tx_data  <= '0;
        end else begin
            tx_valid <= s1_valid;
            if (s1_valid) begin
                tx_tid  <= s1_tid;
                tx_data <= rd_data;
            end
        end
    end

    always_comb begin
        tx_mmio_channel             = '0;
        tx_mmio_channel.mmioRdValid = tx_valid;
        tx_mmio_channel.hdr.tid     = tx_tid;
        tx_mmio_channel.data        = tx_data;
    end

endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// Bench for hc_mmio_rd_responder: a byte-offset register model predicts every c2
// response cycle by cycle; literal expectations pin the key reads independently.

module tb_hc_mmio_rd_responder;
    import hc_ccip_pkg::*;

    localparam logic [63:0] ID_L    = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ID_H    = 64'hFEDC_BA98_7654_3210;
    localparam int          NBUF    = 2;
    localparam logic [63:0] DFH_VAL = 64'h1000_0100_0000_0000;

    logic           clk = 1'b0;
    logic           reset;
    t_if_ccip_c0_Rx rx;
    t_if_ccip_c2_Tx tx;
    logic [63:0]    hc_status;

    hc_mmio_rd_responder #(
        .AFU_ID_L(ID_L), .AFU_ID_H(ID_H), .HC_BUFFER_SIZE(NBUF)
    ) dut (
        .clk(clk), .reset(reset), .rx_mmio_channel(rx),
        .tx_mmio_channel(tx), .hc_status(hc_status)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    typedef struct { int due; logic [8:0] tid; logic [63:0] data; } rsp_t;
    typedef struct { int due; logic [63:0] data; string name; } lit_t;
    rsp_t exp_q[$];
    lit_t lit_q[$];

    logic [63:0] m_regs [int];
    logic [31:0] m_cnt;
    logic        p_valid;
    logic [15:0] p_dw;
    logic [1:0]  p_len;
    logic [8:0]  p_tid;
    logic [31:0] p_cnt;
    int          p_due;

    function automatic bit is_buf(input int off);
        return off >= 'h120 && off < 'h120 + 'h10 * NBUF;
    endfunction

    function automatic bit writable(input int off);
        return off == 'h110 || off == 'h118 || is_buf(off);
    endfunction

    function automatic bit is32(input int off);
        return off == 'h118 || (is_buf(off) && (off % 'h10) == 8);
    endfunction

    function automatic logic [63:0] model_word(input int off, input logic [31:0] cnt);
        if (off == 'h000) return DFH_VAL;
        if (off == 'h008) return ID_L;
        if (off == 'h010) return ID_H;
        if (off == 'h200) return {32'h0, cnt};
        if (off == 'h208) return hc_status;
        if (m_regs.exists(off)) return m_regs[off];
        return 64'h0;
    endfunction

    task automatic model_write(input logic [15:0] dw, input logic [1:0] len, input logic [63:0] d);
        int          off;
        logic [63:0] old;
        logic [63:0] nv;
        off = (int'(dw) * 4) & ~7;
        if (!writable(off)) return;
        old = m_regs.exists(off) ? m_regs[off] : 64'h0;
        if (len != 2'd0) nv = d;
        else if (dw[0])  nv = {d[31:0], old[31:0]};
        else             nv = {old[63:32], d[31:0]};
        if (is32(off)) nv[63:32] = 32'h0;
        m_regs[off] = nv;
    endtask

    task automatic model_clear();
        m_regs.delete();
        m_cnt   = 32'h0;
        p_valid = 1'b0;
        exp_q.delete();
        lit_q.delete();
    endtask

    // One call per cycle: this cycle's write, then resolve last cycle's read, then accept this read.
    task automatic model_step();
        logic [63:0] w;
        logic [63:0] d;
        if (rx.mmioWrValid && rx.hdr.address < 16'h400)
            model_write(rx.hdr.address, rx.hdr.length, rx.data[63:0]);
        if (p_valid) begin
            w = model_word((int'(p_dw) * 4) & ~7, p_cnt);
            if (p_len != 2'd0) d = w;
            else if (p_dw[0])  d = {32'h0, w[63:32]};
            else               d = {32'h0, w[31:0]};
            exp_q.push_back('{p_due, p_tid, d});
            p_valid = 1'b0;
        end
        if (rx.mmioRdValid && rx.hdr.address < 16'h400) begin
            p_valid = 1'b1;
            p_dw    = rx.hdr.address;
            p_len   = rx.hdr.length;
            p_tid   = rx.hdr.tid;
            p_cnt   = m_cnt;
            p_due   = cyc + 2;
            m_cnt   = m_cnt + 32'd1;
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        rsp_t e;
        lit_t l;
        if (started) begin
            if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                e = exp_q.pop_front();
                check("rsp_missed_due", 64'(e.due), 64'(cyc));
            end
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("rsp_valid", 64'(tx.mmioRdValid), 64'd1);
                check("rsp_tid", 64'(tx.hdr.tid), 64'(e.tid));
                check("rsp_data", tx.data, e.data);
            end else begin
                check("idle_valid", 64'(tx.mmioRdValid), 64'd0);
            end
            if (lit_q.size() != 0 && lit_q[0].due == cyc) begin
                l = lit_q.pop_front();
                check(l.name, tx.data, l.data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rd_v, input logic wr_v, input logic [15:0] dw,
                         input logic [1:0] len, input logic [8:0] tid, input logic [63:0] d);
        logic [31:0] c;
        @(posedge clk);
        #1;
        c = 32'(cyc);
        rx                 = '0;
        rx.mmioRdValid     = rd_v;
        rx.mmioWrValid     = wr_v;
        rx.hdr.address     = dw;
        rx.hdr.length      = len;
        rx.hdr.tid         = tid;
        rx.data[63:0]      = d;
        hc_status          = {32'hC0DE_0000 ^ c, c * 32'h9E37_79B9};
        model_step();
    endtask

    task automatic rd(input int byte_off, input logic [1:0] len, input logic [8:0] tid);
        drive(1'b1, 1'b0, 16'(byte_off >> 2), len, tid, 64'h0);
    endtask

    task automatic rd_lit(input int byte_off, input logic [1:0] len, input logic [8:0] tid,
                          input string name, input logic [63:0] lit);
        rd(byte_off, len, tid);
        lit_q.push_back('{cyc + 2, lit, name});
    endtask

    task automatic wr(input int byte_off, input logic [1:0] len, input logic [63:0] d);
        drive(1'b0, 1'b1, 16'(byte_off >> 2), len, 9'h0, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        rx    = '0;
        model_clear();
        #1;
        check("rst_valid", 64'(tx.mmioRdValid), 64'd0);
        check("rst_tid", 64'(tx.hdr.tid), 64'd0);
        check("rst_data", tx.data, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        rx        = '0;
        hc_status = 64'h0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("init_valid", 64'(tx.mmioRdValid), 64'd0);
        check("init_tid", 64'(tx.hdr.tid), 64'd0);
        check("init_data", tx.data, 64'd0);
        reset   = 1'b0;
        started = 1'b1;

        // constants
        rd_lit('h000, 2'd1, 9'h05, "dfh", DFH_VAL);
        rd_lit('h008, 2'd1, 9'h06, "afu_id_l", ID_L);
        rd_lit('h010, 2'd1, 9'h07, "afu_id_h", ID_H);
        rd_lit('h018, 2'd2, 9'h08, "zero_018", 64'h0);

        // DSM shadow, full and half reads
        wr('h110, 2'd1, 64'hDEAD_BEEF_0123_4567);
        rd_lit('h110, 2'd1, 9'h09, "dsm_full", 64'hDEAD_BEEF_0123_4567);
        rd_lit('h114, 2'd0, 9'h0A, "dsm_hi", 64'h0000_0000_DEAD_BEEF);
        rd_lit('h110, 2'd0, 9'h0B, "dsm_lo", 64'h0000_0000_0123_4567);

        // buffer shadows and 4B writes
        wr('h120, 2'd1, 64'h0);
        wr('h124, 2'd0, 64'h0000_0000_AAAA_5555);
        rd_lit('h120, 2'd1, 9'h0C, "buf0_addr_hi4", 64'hAAAA_5555_0000_0000);
        wr('h138, 2'd0, 64'h40);
        wr('h13C, 2'd0, 64'hFFFF_FFFF);
        rd_lit('h138, 2'd1, 9'h0D, "buf1_size", 64'h40);
        wr('h118, 2'd1, 64'hFFFF_FFFF_1234_5678);
        rd_lit('h118, 2'd1, 9'h0E, "ctrl_32b", 64'h0000_0000_1234_5678);

        // write one cycle after a read is still seen by that read
        rd_lit('h130, 2'd1, 9'h0F, "late_write", 64'h5A5A_0000_0000_1234);
        wr('h130, 2'd1, 64'h5A5A_0000_0000_1234);
        idle(3);

        // back-to-back reads from a fresh counter
        apply_reset();
        rd('h000, 2'd1, 9'h01);
        rd('h008, 2'd1, 9'h02);
        rd('h300, 2'd1, 9'h03);
        rd('h110, 2'd1, 9'h04);
        rd_lit('h200, 2'd1, 9'h05, "cnt_burst", 64'd4);

        // unmapped, unowned, read-only and aliased accesses
        rd_lit('h300, 2'd1, 9'h06, "unmapped", 64'h0);
        rd_lit('h200, 2'd1, 9'h07, "cnt_after_unmapped", 64'd6);
        drive(1'b1, 1'b0, 16'h0400, 2'd1, 9'h1FF, 64'h0);
        rd_lit('h200, 2'd0, 9'h08, "cnt_after_unowned", 64'd7);
        rd('h208, 2'd1, 9'h09);
        rd('h20C, 2'd0, 9'h0A);
        wr('h000, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_lit('h000, 2'd1, 9'h0B, "dfh_ro", DFH_VAL);
        drive(1'b0, 1'b1, 16'h0444, 2'd1, 9'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_lit('h110, 2'd1, 9'h0C, "alias_ignored", 64'h0);

        // reset with a read in flight
        wr('h118, 2'd1, 64'h0000_0000_0BAD_F00D);
        idle(3);
        rd('h000, 2'd1, 9'h03);
        apply_reset();
        rd_lit('h200, 2'd1, 9'h01, "cnt_after_reset", 64'h0);
        rd_lit('h118, 2'd1, 9'h02, "ctrl_after_reset", 64'h0);
        idle(4);

        if (exp_q.size() != 0 || lit_q.size() != 0)
            check("queues_drained", 64'(exp_q.size() + lit_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
